screen_scanner: RTL and testbench

Reads the 8192-word memory-mapped screen region of data memory in raster order and emits a 1-bit pixel stream with valid/ready handshake plus line/frame markers. It is the consumer of the screen region: the CPU writes it through data memory, and this block reads it through a dedicated read port and feeds the display driver. The screen is 512×256 pixels, 32 words per row. Pixel column c of a row is bit (c mod 16) of word (row·32 + c/16), LSB leftmost.

---
 rtl/screen_scanner.sv | 153 +++++++++++++++
 tb/tb_screen_scanner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/screen_scanner.sv
// Raster scanner: fetches screen words in order and serializes them LSB-first as a
// valid/ready pixel stream with sol/sof/frame_done markers. Define SCANNER_PREFETCH_EN for a gap-free stream.
module screen_scanner #(
  parameter int WORDS_PER_ROW = 32,
  parameter int ROWS          = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        fb_rd_en,
  output logic [12:0] fb_adr,
  input  logic [15:0] fb_data,
  output logic        pix,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        sol,
  output logic        sof,
  output logic        frame_done
);
  localparam logic [12:0] LAST_WORD = 13'(WORDS_PER_ROW * ROWS - 1);
  localparam logic [12:0] COL_MASK  = 13'(WORDS_PER_ROW - 1);

  typedef enum logic [1:0] {IDLE, READ, LOAD, STREAM} state_t;

  state_t      state;
  logic [12:0] word_ptr;
  logic [3:0]  bit_cnt;
  logic [15:0] shreg;
  logic [12:0] next_ptr;
  logic        xfer;
  logic        word_end;
  logic        frame_end;

  function automatic logic [12:0] wrap_inc(input logic [12:0] p);
    return (p == LAST_WORD) ? 13'd0 : p + 13'd1;
  endfunction

  function automatic logic row_start(input logic [12:0] p);
    return (p & COL_MASK) == 13'd0;
  endfunction

  assign next_ptr  = wrap_inc(word_ptr);
  assign xfer      = (state == STREAM) && pix_ready;
  assign word_end  = xfer && (bit_cnt == 4'd15);
  assign frame_end = word_end && (word_ptr == LAST_WORD);
  assign pix       = shreg[0];

`ifdef SCANNER_PREFETCH_EN
  logic [15:0] pbuf;
  logic        pbuf_full;
  logic        pf_capture;

  // NOTE: pbuf is pure datapath qualified by pbuf_full, so it is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (pf_capture) pbuf <= fb_data;
  end
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch sees the pre-edge values of word_ptr, bit_cnt and shreg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_ptr   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      fb_rd_en   <= 1'b0;
      fb_adr     <= '0;
      pix_valid  <= 1'b0;
      sol        <= 1'b0;
      sof        <= 1'b0;
      frame_done <= 1'b0;
`ifdef SCANNER_PREFETCH_EN
      pbuf_full  <= 1'b0;
      pf_capture <= 1'b0;
`endif
    end else begin
      fb_rd_en   <= 1'b0;
      frame_done <= 1'b0;
`ifdef SCANNER_PREFETCH_EN
      // Read data arrives the cycle after the prefetch strobe issued in STREAM.
      pf_capture <= fb_rd_en && (state == STREAM);
      if (pf_capture) pbuf_full <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= READ;
            word_ptr <= '0;
            fb_rd_en <= 1'b1;
            fb_adr   <= '0;
          end
        end
        READ: state <= LOAD;
        LOAD: begin
          shreg     <= fb_data;
          bit_cnt   <= '0;
          state     <= STREAM;
          pix_valid <= 1'b1;
          sol       <= row_start(word_ptr);
          sof       <= (word_ptr == 13'd0);
`ifdef SCANNER_PREFETCH_EN
          fb_rd_en  <= 1'b1;
          fb_adr    <= next_ptr;
`endif
        end
        STREAM: begin
          if (word_end) begin
            word_ptr <= next_ptr;
            if (frame_end) frame_done <= 1'b1;
`ifdef SCANNER_PREFETCH_EN
            pbuf_full <= 1'b0;
            if (frame_end && !enable) begin
              state     <= IDLE;
              pix_valid <= 1'b0;
              sol       <= 1'b0;
              sof       <= 1'b0;
            end else if (pbuf_full) begin
              shreg    <= pbuf;
              bit_cnt  <= '0;
              sol      <= row_start(next_ptr);
              sof      <= (next_ptr == 13'd0);
              fb_rd_en <= 1'b1;
              fb_adr   <= wrap_inc(next_ptr);
            end else begin
              // Prefetch never landed: fall back to a plain fetch of the next word.
              state     <= READ;
              pix_valid <= 1'b0;
              fb_rd_en  <= 1'b1;
              fb_adr    <= next_ptr;
            end
`else
            pix_valid <= 1'b0;
            if (frame_end && !enable) begin
              state <= IDLE;
            end else begin
              state    <= READ;
              fb_rd_en <= 1'b1;
              fb_adr   <= next_ptr;
            end
`endif
          end else if (xfer) begin
            shreg   <= {1'b0, shreg[15:1]};
            bit_cnt <= bit_cnt + 4'd1;
            sol     <= 1'b0;
            sof     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_screen_scanner.sv
// Self-checking bench for screen_scanner: pixel-index reference model plus directed
// reset, bit-order, backpressure, row, frame-wrap and throughput checks.
module tb_screen_scanner;
  localparam int WPR    = 32;
  localparam int ROWS   = 16;   // short frame keeps full-frame runs brief
  localparam int NWORDS = WPR * ROWS;
  localparam int NPIX   = NWORDS * 16;
`ifdef SCANNER_PREFETCH_EN
  localparam int FRAME_CYCLES = 8194;  // 2 + 16*512
  localparam int ROW_RD_ADR   = 33;
`else
  localparam int FRAME_CYCLES = 9216;  // 18*512
  localparam int ROW_RD_ADR   = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        fb_rd_en;
  logic [12:0] fb_adr;
  logic [15:0] fb_data;
  logic        pix;
  logic        pix_valid;
  logic        pix_ready;
  logic        sol;
  logic        sof;
  logic        frame_done;

  logic [15:0] mem [0:8191];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_idx, exp_rd, pix_total, frames, last_rd;
  bit          done_due;
  logic [2:0]  obs [$];
  int          w, b;
  logic        e_pix, e_sol, e_sof;

  screen_scanner #(.WORDS_PER_ROW(WPR), .ROWS(ROWS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .fb_rd_en  (fb_rd_en),
    .fb_adr    (fb_adr),
    .fb_data   (fb_data),
    .pix       (pix),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .sol       (sol),
    .sof       (sof),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Read port: data valid exactly one cycle after the strobe, garbage otherwise.
  always @(posedge clk) fb_data <= fb_rd_en ? mem[fb_adr] : 16'($urandom);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_idx   = 0;
    exp_rd    = 0;
    pix_total = 0;
    frames    = 0;
    done_due  = 1'b0;
    obs.delete();
  endtask

  task automatic wait_pix(input int target, input int budget, input bit rnd);
    int n = 0;
    while (pix_total < target && n < budget) begin
      if (rnd) pix_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      n++;
    end
    if (pix_total < target) check("wait_pix_timeout", 32'(pix_total), 32'(target));
  endtask

  task automatic wait_rd(input string name);
    int n = 0;
    while (!fb_rd_en && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(fb_rd_en), 32'd1);
  endtask

  // Reference model: the frame is a flat sequence of pixel indices; pixel p is bit p%16
  // of word p/16, reads are issued for consecutive words in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fb_rd_en) begin
        check("rd_adr", 32'(fb_adr), 32'(exp_rd));
        exp_rd  = (exp_rd + 1) % NWORDS;
        last_rd = int'(fb_adr);
      end
      check("frame_done", 32'(frame_done), 32'(done_due));
      done_due = 1'b0;
      if (pix_valid) begin
        w     = exp_idx / 16;
        b     = exp_idx % 16;
        e_pix = mem[w][b];
        e_sol = (exp_idx % (16 * WPR)) == 0;
        e_sof = (exp_idx == 0);
        check("pix", 32'(pix), 32'(e_pix));
        check("sol", 32'(sol), 32'(e_sol));
        check("sof", 32'(sof), 32'(e_sof));
        if (pix_ready) begin
          obs.push_back({pix, sol, sof});
          pix_total++;
          exp_idx++;
          if (exp_idx == NPIX) begin
            exp_idx  = 0;
            done_due = 1'b1;
            frames++;
          end
        end
      end
    end
  end

  initial begin
    int c;
    logic [2:0] e;
    rst_n     = 1'b0;
    enable    = 1'b0;
    pix_ready = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0001;
    mem[1] = 16'h8000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_fb_rd_en", 32'(fb_rd_en), 32'd0);
    check("rst_fb_adr", 32'(fb_adr), 32'd0);
    check("rst_pix", 32'(pix), 32'd0);
    check("rst_sol", 32'(sol), 32'd0);
    check("rst_sof", 32'(sof), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    // Bit order and first-word latency
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_rd", 32'(fb_rd_en), 32'd0);
    enable    = 1'b1;
    pix_ready = 1'b1;
    @(posedge clk); #1;
    check("first_rd_en", 32'(fb_rd_en), 32'd1);
    check("first_rd_adr", 32'(fb_adr), 32'd0);
    @(posedge clk); #1;
    check("load_not_valid", 32'(pix_valid), 32'd0);
    @(posedge clk); #1;
    check("first_valid", 32'(pix_valid), 32'd1);
    wait_pix(32, 200, 1'b0);
    for (int i = 0; i < 32; i++) begin
      e = (i == 0) ? 3'b111 : ((i == 31) ? 3'b100 : 3'b000);
      check("bit_order", 32'(obs[i]), 32'(e));
    end

    // Asynchronous reset in the middle of word 100
    wait_pix(100 * 16 + 5, 3000, 1'b0);
    check("pre_rst_valid", 32'(pix_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_pix_valid", 32'(pix_valid), 32'd0);
    check("arst_fb_rd_en", 32'(fb_rd_en), 32'd0);
    check("arst_sol", 32'(sol), 32'd0);
    check("arst_sof", 32'(sof), 32'd0);
    check("arst_frame_done", 32'(frame_done), 32'd0);
    model_reset();
    mem[0] = 16'h0008;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_rd("restart_rd_en");
    check("restart_adr", 32'(fb_adr), 32'd0);

    // Backpressure at bit 3 of word 0
    wait_pix(3, 50, 1'b0);
    pix_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(pix_valid), 32'd1);
      check("bp_pix", 32'(pix), 32'd1);
      check("bp_no_rd", 32'(fb_rd_en), 32'd0);
      @(posedge clk); #1;
    end
    check("bp_no_xfer", 32'(pix_total), 32'd3);
    pix_ready = 1'b1;
    wait_pix(5, 50, 1'b0);
    check("bp_bit0", 32'(obs[0]), 32'(3'b011));
    check("bp_bit3", 32'(obs[3]), 32'(3'b100));
    check("bp_bit4", 32'(obs[4]), 32'(3'b000));

    // Row boundary after word 31
    wait_pix(32 * 16 + 1, 3000, 1'b1);
    check("row_first_pix", 32'(obs[32 * 16]), 32'({mem[32][0], 2'b10}));
    check("row_rd_adr", 32'(last_rd), 32'(ROW_RD_ADR));

    // enable dropped mid-frame: frame completes, then idle
    wait_pix(300 * 16, 20000, 1'b1);
    enable = 1'b0;
    wait_pix(NPIX, 20000, 1'b1);
    check("done_pulse", 32'(frame_done), 32'd1);
    check("frames_done", 32'(frames), 32'd1);
    pix_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      check("idle_no_rd", 32'(fb_rd_en), 32'd0);
      check("idle_no_valid", 32'(pix_valid), 32'd0);
    end

    // Throughput and wrap into the next frame with enable held
    model_reset();
    enable = 1'b1;
    wait_rd("tp_first_rd");
    c = 0;
    while (!frame_done && c < FRAME_CYCLES + 100) begin
      @(posedge clk); #1;
      c++;
    end
    check("frame_cycles", 32'(c), 32'(FRAME_CYCLES));
    wait_pix(NPIX + 1, 100, 1'b0);
    check("wrap_sof", 32'(obs[NPIX]), 32'({mem[0][0], 2'b11}));
    check("wrap_frames", 32'(frames), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
